// File: rtl/packet_flit_injector.sv
// ---------------------------------------------------------------------------
// packet_flit_injector
//
// Frames packets for a NoC injection port. A descriptor (target, size) is
// accepted in IDLE, then the block emits a header flit (target), a size flit
// and `size` payload flits taken from an internal payload FIFO. Every flit is
// handed over with credit flow control: a flit moves when tx_o & credit_i.
// Payload words may be written into the FIFO at any time, so a packet's
// payload can be preloaded before its descriptor arrives. A sticky
// end-of-application flag raises eoa_o once all traffic has drained.
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   pkt_valid_i    descriptor valid; accepted when pkt_ready_o (IDLE)
//   pkt_ready_o    descriptor ready
//   pkt_target_i   destination PE address {x[15:8], y[7:0]}
//   pkt_size_i     payload flit count (0 is legal)
//   pld_valid_i    payload word valid
//   pld_ready_o    payload FIFO not full
//   pld_data_i     payload word
//   eoa_i          end-of-application indication from the loader
//   tx_o           flit valid toward the NoC
//   credit_i       NoC can take a flit this cycle
//   data_o         flit
//   eoa_o          all packets sent after end-of-application was seen
//   busy_o         framer not idle
//   pkt_count_o    packets fully sent (wraps)
// ---------------------------------------------------------------------------
module packet_flit_injector #(
    parameter int FLIT_SIZE = 32,
    parameter int BUF_DEPTH = 16,
    parameter int SIZE_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [15:0]          pkt_target_i,
    input  logic [SIZE_W-1:0]    pkt_size_i,
    input  logic                 pld_valid_i,
    output logic                 pld_ready_o,
    input  logic [FLIT_SIZE-1:0] pld_data_i,
    input  logic                 eoa_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 eoa_o,
    output logic                 busy_o,
    output logic [15:0]          pkt_count_o
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    state_t                state_q, state_next;
    logic [15:0]           target_q;
    logic [SIZE_W-1:0]     remaining_q;   // holds the size until the size flit leaves
    logic [15:0]           pkt_count_q;
    logic                  eoa_flag_q;

    logic [FLIT_SIZE-1:0]  mem [BUF_DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q;  // extra MSB tells full from empty

    logic fifo_empty, fifo_full;
    logic push, pop, xfer, pkt_done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses writes even when a pop happens in the same cycle,
    // which keeps pld_ready_o free of any path from credit_i.
    assign push = pld_valid_i & ~fifo_full;
    assign xfer = tx_o & credit_i;
    assign pop  = xfer & (state_q == S_PAYLOAD);

    // A packet is complete on its size flit when empty, else on its last payload flit.
    assign pkt_done = (xfer && state_q == S_SIZE && remaining_q == '0) ||
                      (pop && remaining_q == SIZE_W'(1));

    // ---------------------------------------------------------------- next state
    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_next  = state_q;
        tx_o        = 1'b0;
        data_o      = '0;
        pkt_ready_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) state_next = S_HEADER;
            end
            S_HEADER: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(target_q);
                if (credit_i) state_next = S_SIZE;
            end
            S_SIZE: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(remaining_q);
                if (credit_i) state_next = (remaining_q == '0) ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // An empty FIFO stalls the packet rather than underflowing.
                tx_o   = ~fifo_empty;
                data_o = mem[rd_ptr_q[AW-1:0]];
                if (pkt_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            eoa_flag_q  <= 1'b0;
        end else begin
            state_q <= state_next;

            if (state_q == S_IDLE && pkt_valid_i) begin
                target_q    <= pkt_target_i;
                remaining_q <= pkt_size_i;
            end else if (pop) begin
                remaining_q <= remaining_q - SIZE_W'(1);
            end

            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);

            if (pkt_done) pkt_count_q <= pkt_count_q + 16'd1;
            if (eoa_i)    eoa_flag_q  <= 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptying the FIFO
    // only needs the pointers cleared, and stale words are never presented.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= pld_data_i;
    end

    // ---------------------------------------------------------------- outputs
    assign pld_ready_o = ~fifo_full;
    assign busy_o      = (state_q != S_IDLE);
    assign pkt_count_o = pkt_count_q;
    // A pending descriptor means more traffic is coming, so it masks eoa_o.
    assign eoa_o       = eoa_flag_q & (state_q == S_IDLE) & fifo_empty & ~pkt_valid_i;

endmodule

// File: tb/tb_packet_flit_injector.sv
// ---------------------------------------------------------------------------
// tb_packet_flit_injector
//
// Directed bench for packet_flit_injector with the default parameters
// (FLIT_SIZE=32, BUF_DEPTH=16, SIZE_W=16). Inputs change one time unit after
// the rising edge and outputs are compared one time unit later.
// ---------------------------------------------------------------------------
module tb_packet_flit_injector;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        pkt_valid, pkt_ready;
    logic [15:0] pkt_target, pkt_size;
    logic        pld_valid, pld_ready;
    logic [31:0] pld_data;
    logic        eoa_in, tx, credit;
    logic [31:0] data;
    logic        eoa_out, busy;
    logic [15:0] pkt_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_flit_injector #(
        .FLIT_SIZE(32),
        .BUF_DEPTH(16),
        .SIZE_W   (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pkt_valid_i (pkt_valid),
        .pkt_ready_o (pkt_ready),
        .pkt_target_i(pkt_target),
        .pkt_size_i  (pkt_size),
        .pld_valid_i (pld_valid),
        .pld_ready_o (pld_ready),
        .pld_data_i  (pld_data),
        .eoa_i       (eoa_in),
        .tx_o        (tx),
        .credit_i    (credit),
        .data_o      (data),
        .eoa_o       (eoa_out),
        .busy_o      (busy),
        .pkt_count_o (pkt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        pld_valid = 1'b1;
        pld_data  = w;
        tick();
        pld_valid = 1'b0;
    endtask

    // Presents a descriptor in IDLE for one cycle; returns in HEADER.
    task automatic accept(input logic [15:0] target, input logic [15:0] size);
        pkt_valid  = 1'b1;
        pkt_target = target;
        pkt_size   = size;
        tick();
        pkt_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; pkt_valid = 1'b0; pkt_target = '0; pkt_size = '0;
        pld_valid = 1'b0; pld_data = '0; eoa_in = 1'b0; credit = 1'b1;
        #12;
        checks++;
        if ({tx, busy, eoa_out, pld_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags: {tx,busy,eoa,pld_ready}=%b expected 0001", {tx, busy, eoa_out, pld_ready});
        end
        checks++;
        if (data !== 32'h0 || pkt_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_data_count: data=%h count=%0d expected 0 and 0", data, pkt_count);
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (pkt_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_pkt_ready: got %b expected 1", pkt_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp [5] = '{32'h0000_0102, 32'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        credit = 1'b1;
        push_word(32'hAAAA_0001);
        push_word(32'hBBBB_0002);
        push_word(32'hCCCC_0003);
        accept(16'h0102, 16'd3);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (tx !== 1'b1 || data !== exp[i] || pkt_ready !== 1'b0) begin
                failures++;
                $display("FAIL basic_flit%0d: tx=%b data=%h ready=%b expected tx=1 data=%h ready=0", i, tx, data, pkt_ready, exp[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_done: tx=%b busy=%b count=%0d expected 0 0 1", tx, busy, pkt_count);
        end
    endtask

    task automatic test_credit_stall();
        logic [31:0] exp [5] = '{32'h0000_0102, 32'd3, 32'hD0D0_0001, 32'hE0E0_0002, 32'hF0F0_0003};
        int          idx = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        push_word(32'hD0D0_0001);
        push_word(32'hE0E0_0002);
        push_word(32'hF0F0_0003);
        accept(16'h0102, 16'd3);
        for (int c = 1; c <= 30 && idx < 5; c++) begin
            credit = !(c >= 2 && c <= 4);
            #1;
            if (tx === 1'b1) begin
                checks++;
                if (data !== exp[idx]) begin
                    failures++;
                    $display("FAIL stall_flit%0d_c%0d: data=%h expected %h", idx, c, data, exp[idx]);
                end
                if (credit) idx++;
            end
            if (prev_stall) begin
                checks++;
                if (tx !== 1'b1 || data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold_c%0d: tx=%b data=%h expected tx=1 data=%h", c, tx, data, prev_data);
                end
            end
            prev_stall = tx & ~credit;
            prev_data  = data;
            tick();
        end
        credit = 1'b1;
        #1;
        checks++;
        if (idx != 5 || tx !== 1'b0 || pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL stall_done: flits=%0d tx=%b count=%0d expected 5 0 2", idx, tx, pkt_count);
        end
    endtask

    task automatic test_zero_size();
        logic [31:0] exp [2] = '{32'h0000_0304, 32'd0};
        accept(16'h0304, 16'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (tx !== 1'b1 || data !== exp[i]) begin
                failures++;
                $display("FAIL zero_flit%0d: tx=%b data=%h expected tx=1 data=%h", i, tx, data, exp[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b0 || pkt_ready !== 1'b1 || pkt_count !== 16'd3) begin
            failures++;
            $display("FAIL zero_done: tx=%b busy=%b ready=%b count=%0d expected 0 0 1 3", tx, busy, pkt_ready, pkt_count);
        end
    endtask

    task automatic test_fifo_full();
        int   idx = 0;
        int   fed = 0;
        logic saw_stall = 1'b0;
        logic [31:0] exp [22];
        exp[0] = 32'h0000_0506;
        exp[1] = 32'd20;
        for (int i = 0; i < 20; i++) exp[i+2] = 32'h5000_0000 + i;
        for (int i = 0; i < 16; i++) begin
            if (pld_ready !== 1'b1) begin
                checks++; failures++;
                $display("FAIL full_early_%0d: pld_ready=%b expected 1", i, pld_ready);
            end
            push_word(32'h5000_0000 + i);
        end
        checks++;
        if (pld_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: pld_ready=%b expected 0", pld_ready);
        end
        // A write offered while full must be dropped.
        push_word(32'hDEAD_BEEF);
        accept(16'h0506, 16'd20);
        for (int c = 0; c < 200 && idx < 22; c++) begin
            if (saw_stall && fed < 4) begin
                pld_valid = 1'b1;
                pld_data  = 32'h5000_0010 + fed;
                fed++;
            end else begin
                pld_valid = 1'b0;
            end
            #1;
            if (idx == 18 && !saw_stall) begin
                checks++;
                if (tx !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL full_empty_stall: tx=%b busy=%b expected 0 1", tx, busy);
                end
                saw_stall = 1'b1;
            end else if (tx === 1'b1) begin
                checks++;
                if (data !== exp[idx]) begin
                    failures++;
                    $display("FAIL full_flit%0d: data=%h expected %h", idx, data, exp[idx]);
                end
                idx++;
            end
            tick();
        end
        pld_valid = 1'b0;
        #1;
        checks++;
        if (idx != 22 || busy !== 1'b0 || pkt_count !== 16'd4) begin
            failures++;
            $display("FAIL full_done: flits=%0d busy=%b count=%0d expected 22 0 4", idx, busy, pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        logic        etx   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] edata [6] = '{32'h0, 32'h0000_0708, 32'h0, 32'h0, 32'h0000_0708, 32'h0};
        pkt_valid  = 1'b1;
        pkt_target = 16'h0708;
        pkt_size   = 16'd0;
        tick();
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (tx !== etx[c] || data !== edata[c]) begin
                failures++;
                $display("FAIL b2b_c%0d: tx=%b data=%h expected tx=%b data=%h", c, tx, data, etx[c], edata[c]);
            end
            tick();
            if (c == 3) pkt_valid = 1'b0;
        end
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_count !== 16'd6) begin
            failures++;
            $display("FAIL b2b_done: busy=%b count=%0d expected 0 6", busy, pkt_count);
        end
    endtask

    task automatic test_eoa();
        logic [31:0] exp1 [3] = '{32'h0000_0A0B, 32'd1, 32'h1111_0001};
        logic [31:0] exp2 [3] = '{32'h0000_0A0C, 32'd1, 32'h2222_0002};
        #1;
        checks++;
        if (eoa_out !== 1'b0) begin
            failures++;
            $display("FAIL eoa_before_flag: eoa=%b expected 0", eoa_out);
        end
        push_word(32'h1111_0001);
        push_word(32'h2222_0002);
        accept(16'h0A0B, 16'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (tx !== 1'b1 || data !== exp1[i] || eoa_out !== 1'b0) begin
                failures++;
                $display("FAIL eoa_pkt1_%0d: tx=%b data=%h eoa=%b expected 1 %h 0", i, tx, data, eoa_out, exp1[i]);
            end
            tick();
        end
        accept(16'h0A0C, 16'd1);
        for (int i = 0; i < 3; i++) begin
            eoa_in = (i == 0);
            #1;
            checks++;
            if (tx !== 1'b1 || data !== exp2[i] || eoa_out !== 1'b0) begin
                failures++;
                $display("FAIL eoa_pkt2_%0d: tx=%b data=%h eoa=%b expected 1 %h 0", i, tx, data, eoa_out, exp2[i]);
            end
            tick();
        end
        eoa_in = 1'b0;
        #1;
        checks++;
        if (eoa_out !== 1'b1 || pkt_count !== 16'd8) begin
            failures++;
            $display("FAIL eoa_drained: eoa=%b count=%0d expected 1 8", eoa_out, pkt_count);
        end
        pkt_valid  = 1'b1;
        pkt_target = 16'h0A0D;
        pkt_size   = 16'd0;
        #1;
        checks++;
        if (eoa_out !== 1'b0) begin
            failures++;
            $display("FAIL eoa_new_desc: eoa=%b expected 0", eoa_out);
        end
        tick();
        pkt_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (eoa_out !== 1'b0 || tx !== 1'b1) begin
                failures++;
                $display("FAIL eoa_pkt3_%0d: eoa=%b tx=%b expected 0 1", i, eoa_out, tx);
            end
            tick();
        end
        #1;
        checks++;
        if (eoa_out !== 1'b1 || pkt_count !== 16'd9) begin
            failures++;
            $display("FAIL eoa_redrained: eoa=%b count=%0d expected 1 9", eoa_out, pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        push_word(32'h7777_0001);
        push_word(32'h7777_0002);
        accept(16'h0C0D, 16'd2);
        tick();
        tick();
        #1;
        checks++;
        if (tx !== 1'b1 || data !== 32'h7777_0001) begin
            failures++;
            $display("FAIL mid_payload: tx=%b data=%h expected 1 77770001", tx, data);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b0 || data !== 32'h0 || busy !== 1'b0 || pld_ready !== 1'b1 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: tx=%b data=%h busy=%b pld_ready=%b count=%0d expected 0 0 0 1 0",
                     tx, data, busy, pld_ready, pkt_count);
        end
        #3;
        rst_ni = 1'b1;
        tick();
        // FIFO must have been emptied: a 1-word packet stalls in PAYLOAD.
        accept(16'h0C0E, 16'd1);
        tick();
        tick();
        #1;
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_fifo_empty: tx=%b busy=%b count=%0d expected 0 1 0", tx, busy, pkt_count);
        end
        push_word(32'h8888_0001);
        #1;
        checks++;
        if (tx !== 1'b1 || data !== 32'h8888_0001) begin
            failures++;
            $display("FAIL mid_resume: tx=%b data=%h expected 1 88880001", tx, data);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_done: busy=%b count=%0d expected 0 1", busy, pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_stall();
        test_zero_size();
        test_fifo_full();
        test_back_to_back();
        test_eoa();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
